generic_dpram_sc: RTL and testbench
===================================

Name: generic_dpram_sc

Overview:
Single-clock simple dual-port RAM with one write port and one registered read port. It is the storage element behind the team's generic FIFOs: the FIFO drives the write port from its write pointer and the read port from its read pointer. Memory depth is 2^aw words of dw bits.

Parameters:
aw, 5, address width; depth = 2^aw words.
dw, 16, data width in bits.
rdw_new, 0, read-during-write to the same address on the same edge: 0 returns old data, 1 returns newly written data.

Ports:
clk  input  1  single clock for both ports; rising edge.
rst  input  1  asynchronous, active-low reset; clears the read output register only.
rce  input  1  read clock enable; the read register updates only when rce=1.
oe  input  1  output enable; gates dout combinationally.
raddr  input  aw  read address.
dout  output  dw  read data.
wce  input  1  write clock enable.
we  input  1  write enable; a write occurs only when wce=1 and we=1.
waddr  input  aw  write address.
di  input  dw  write data.

Behaviour:
- Storage: array of 2^aw words of dw bits. Contents are not reset; they are X in simulation until written.
- Write: on posedge clk with wce & we = 1, mem[waddr] <= di. No write otherwise. All waddr values are valid; there is no out-of-range case.
- Read latency is 1 cycle. On posedge clk with rce=1, the read register q <= mem[raddr]. With rce=0, q holds its value.
- dout = oe ? q : {dw{1'b0}}. This path is purely combinational, so a change in oe takes effect immediately without waiting for a clock edge.
- Read-during-write, same address, same edge, rce=1 and a write active:
  - rdw_new=0: q receives the pre-write contents.
  - rdw_new=1: q receives di (bypass).
- Read and write to different addresses on the same edge are independent.
- Reset: rst=0 forces q to 0 asynchronously, independent of clk, so dout=0.
  - While rst=0, writes are blocked.
  - After deassertion, the first rising edge behaves normally.
  - Reset asserted mid-operation leaves memory contents intact. Data written before reset is readable afterwards.
- Undefined addresses (X/Z) on raddr: q becomes X in simulation. No other side effect.
- Synthesis target: the read register must map onto the block-RAM output register.

Test Plan:
1. Reset: rst=0 with q previously 0xA5A5 -> dout=0 immediately, without a clock edge. Release rst, write 0x1234 to addr 3, read addr 3 with rce=1, oe=1 -> dout=0x1234 one cycle after the read edge.
2. Fill and readback: write value addr*3+1 to all 32 addresses (aw=5), then read sequentially -> each dout matches, with 1-cycle latency. Addresses 0 and 31 are both covered.
3. Enables:
   - we=1, wce=0 to addr 5 -> addr 5 keeps its old value.
   - rce=0 while raddr changes -> dout holds.
   - oe=0 -> dout=0; oe back to 1 -> previous q reappears with no clock edge.
4. Read-during-write: addr 7 holds 0x1111; same-edge write 0x2222 and read of addr 7 -> dout=0x1111 with rdw_new=0, dout=0x2222 with rdw_new=1. The next read returns 0x2222 in both cases.
5. Concurrent ports: each cycle, write addr i while reading addr i-1 for 32 cycles -> every read returns the value written the previous cycle.
6. Reset mid-stream: assert rst=0 for 2 cycles during a streaming read -> dout=0 during reset. After release, data written before reset reads back unchanged.

Source files
------------

// File: rtl/generic_dpram_sc.sv
// generic_dpram_sc: single-clock simple dual-port RAM with a registered read port.
module generic_dpram_sc #(
  parameter int aw      = 5,
  parameter int dw      = 16,
  parameter int rdw_new = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rce,
  input  logic          oe,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] dout,
  input  logic          wce,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] di
);
  logic [dw-1:0] mem [2**aw];
  logic [dw-1:0] q_q, q_d;
  logic          wr;
  assign wr = rst & wce & we;
  always_ff @(posedge clk)
    if (wr) mem[waddr] <= di;
  // Bypass only when asked; otherwise the array read sees pre-write contents.
  assign q_d = (rdw_new != 0 && wr && raddr == waddr) ? di : mem[raddr];
  // Kept separate from the array so it maps onto the block-RAM output register.
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else if (rce) q_q <= q_d;
  assign dout = oe ? q_q : '0;
endmodule

// File: tb/tb_generic_dpram_sc.sv
// tb_generic_dpram_sc: scoreboard bench driving old-data and new-data RAM variants in lockstep.
module tb_generic_dpram_sc;
  logic        clk = 0;
  logic        rst, rce, oe, wce, we;
  logic [4:0]  raddr, waddr;
  logic [15:0] di, d0, d1;
  logic [15:0] model [32];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int checks = 0;
  int errors = 0;

  generic_dpram_sc #(.aw(5), .dw(16), .rdw_new(0)) u0 (
    .clk(clk), .rst(rst), .rce(rce), .oe(oe), .raddr(raddr), .dout(d0),
    .wce(wce), .we(we), .waddr(waddr), .di(di));
  generic_dpram_sc #(.aw(5), .dw(16), .rdw_new(1)) u1 (
    .clk(clk), .rst(rst), .rce(rce), .oe(oe), .raddr(raddr), .dout(d1),
    .wce(wce), .we(we), .waddr(waddr), .di(di));

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [4:0] wa, input logic [15:0] wd,
                      input logic r, input logic [4:0] ra, input string nm);
    logic [15:0] e0, e1;
    wce = w; we = w; waddr = wa; di = wd; rce = r; raddr = ra; oe = 1;
    if (r) begin
      q0.push_back(model[ra]);
      q1.push_back((w && wa == ra) ? wd : model[ra]);
    end
    if (w && rst) model[wa] = wd;
    @(posedge clk); #1;
    wce = 0; we = 0; rce = 0;
    if (r) begin
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 2;
      if (d0 !== e0) begin errors++; $display("FAIL %s old: dout=%h expected %h", nm, d0, e0); end
      if (d1 !== e1) begin errors++; $display("FAIL %s new: dout=%h expected %h", nm, d1, e1); end
    end
  endtask

  task automatic test_reset;
    rst = 0; rce = 0; oe = 1; wce = 0; we = 0; raddr = 0; waddr = 0; di = 0;
    #3;
    checks++;
    if (d0 !== 0 || d1 !== 0) begin errors++; $display("FAIL reset_state: dout=%h/%h expected 0", d0, d1); end
    rst = 1;
    step(1, 0, 16'hA5A5, 0, 0, "w_a5a5");
    step(0, 0, 0, 1, 0, "rd_a5a5");
    rst = 0; #1;
    checks++;
    if (d0 !== 0 || d1 !== 0) begin errors++; $display("FAIL async_clear: dout=%h/%h expected 0", d0, d1); end
    #2 rst = 1;
    step(1, 3, 16'h1234, 0, 0, "w_1234");
    step(0, 0, 0, 1, 3, "rd_1234");
  endtask

  task automatic test_fill;
    for (int a = 0; a < 32; a++) step(1, 5'(a), 16'(a * 3 + 1), 0, 0, "fill_w");
    for (int a = 0; a < 32; a++) step(0, 0, 0, 1, 5'(a), "fill_rd");
  endtask

  task automatic test_enables;
    wce = 0; we = 1; waddr = 5; di = 16'hDEAD; rce = 0;
    @(posedge clk); #1;
    we = 0;
    step(0, 0, 0, 1, 5, "wce_block");
    step(0, 0, 0, 1, 10, "rd10");
    rce = 0; raddr = 20;
    @(posedge clk); #1;
    raddr = 21;
    @(posedge clk); #1;
    checks++;
    if (d0 !== model[10] || d1 !== model[10]) begin
      errors++; $display("FAIL rce_hold: dout=%h/%h expected %h", d0, d1, model[10]);
    end
    oe = 0; #1;
    checks++;
    if (d0 !== 0 || d1 !== 0) begin errors++; $display("FAIL oe_low: dout=%h/%h expected 0", d0, d1); end
    oe = 1; #1;
    checks++;
    if (d0 !== model[10] || d1 !== model[10]) begin
      errors++; $display("FAIL oe_restore: dout=%h/%h expected %h", d0, d1, model[10]);
    end
  endtask

  task automatic test_rdw;
    step(1, 7, 16'h1111, 0, 0, "w_1111");
    step(1, 7, 16'h2222, 1, 7, "rdw_same_edge");
    step(0, 0, 0, 1, 7, "rdw_after");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++)
      step(1, 5'(i), 16'($urandom), 1, 5'(i - 1), "concurrent");
  endtask

  task automatic test_reset_midstream;
    for (int a = 0; a < 4; a++) step(0, 0, 0, 1, 5'(a), "stream_rd");
    rst = 0; rce = 1; raddr = 4; wce = 1; we = 1; waddr = 9; di = 16'hBEEF; #1;
    checks++;
    if (d0 !== 0 || d1 !== 0) begin errors++; $display("FAIL mid_reset_async: dout=%h/%h expected 0", d0, d1); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (d0 !== 0 || d1 !== 0) begin errors++; $display("FAIL mid_reset_hold: dout=%h/%h expected 0", d0, d1); end
    end
    wce = 0; we = 0; rce = 0;
    rst = 1;
    step(0, 0, 0, 1, 9, "wr_blocked");
    for (int a = 4; a < 8; a++) step(0, 0, 0, 1, 5'(a), "post_reset_rd");
  endtask

  initial begin
    test_reset;
    test_fill;
    test_enables;
    test_rdw;
    test_back_to_back;
    test_reset_midstream;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: left=%0d/%0d expected 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
